// File: rtl/cp0_nway.sv
// cp0_nway: multi-issue MIPS CP0 with timer, interrupts, exception/ERET redirect and MTC0 write merging.
module cp0_nway #(
  parameter int          WAYS      = 2,
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 ex_cp0_re,
  input  logic [WAYS*5-1:0]    ex_cp0_raddr,
  output logic [WAYS*32-1:0]   ex_cp0_rdata,
  input  logic [WAYS-1:0]      wb_cp0_we,
  input  logic [WAYS*5-1:0]    wb_cp0_waddr,
  input  logic [WAYS*32-1:0]   wb_cp0_wdata,
  input  logic [5:0]           int_i,
  input  logic [WAYS*32-1:0]   ex_exc_pc,
  input  logic [WAYS-1:0]      ex_in_delay,
  input  logic [WAYS*5-1:0]    ex_exc_code,
  input  logic [WAYS*32-1:0]   ex_badvaddr,
  output logic                 exc_flush_all,
  output logic                 exc_flush_icache,
  output logic [31:0]          cp0_if_excaddr,
  output logic                 timer_int_o
);
  localparam int DW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  // write-port slot order: BadVAddr, Count, Compare, Status, Cause, EPC
  localparam logic [29:0] REG_ID = {5'd14, 5'd13, 5'd12, 5'd11, 5'd9, 5'd8};
  localparam logic [4:0]  C_NONE = 5'h10;
  localparam logic [4:0]  C_ERET = 5'h11;

  logic [31:0]   r_badvaddr, r_count, r_compare, r_epc;
  logic [7:0]    r_im, r_ip;
  logic          r_exl, r_ie, r_bd, r_ti, r_flush;
  logic [4:0]    r_exc;
  logic [DW-1:0] r_div;

  logic [31:0] w_status, w_cause, w_pc, w_bad, w_cnt1;
  logic [31:0] w_wd [6];
  logic [5:0]  w_hit, w_wen;
  logic [4:0]  w_code, w_ra;
  logic        w_int, w_any, w_dly, w_eret, w_take, w_tick, w_inc;

  assign w_status = {16'h0, r_im, 6'h0, r_exl, r_ie};
  assign w_cause  = {r_bd, r_ti, 14'h0, r_ip, 1'b0, r_exc, 2'b0};

  always_comb begin
    ex_cp0_rdata = '0;
    w_ra = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_ra = ex_cp0_raddr[5*i+:5];
      ex_cp0_rdata[32*i+:32] = !ex_cp0_re   ? 32'h0 :
                               w_ra == 5'd8  ? r_badvaddr :
                               w_ra == 5'd9  ? r_count :
                               w_ra == 5'd11 ? r_compare :
                               w_ra == 5'd12 ? w_status :
                               w_ra == 5'd13 ? w_cause :
                               w_ra == 5'd14 ? r_epc : 32'h0;
    end
  end

  // later ways overwrite earlier ones so the youngest writer wins
  always_comb begin
    w_hit = '0;
    for (int r = 0; r < 6; r++) w_wd[r] = '0;
    for (int i = 0; i < WAYS; i++)
      for (int r = 0; r < 6; r++)
        if (wb_cp0_we[i] && wb_cp0_waddr[5*i+:5] == REG_ID[5*r+:5]) begin
          w_hit[r] = 1'b1;
          w_wd[r]  = wb_cp0_wdata[32*i+:32];
        end
  end

  // descending scan leaves the oldest faulting way selected
  always_comb begin
    w_int  = |(r_im & r_ip) & r_ie & ~r_exl;
    w_any  = 1'b0;
    w_code = C_NONE;
    w_pc   = '0;
    w_dly  = 1'b0;
    w_bad  = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if ((i == 0 && w_int) || ex_exc_code[5*i+:5] != C_NONE) begin
        w_any  = 1'b1;
        w_code = (i == 0 && w_int) ? 5'h00 : ex_exc_code[5*i+:5];
        w_pc   = ex_exc_pc[32*i+:32];
        w_dly  = ex_in_delay[i];
        w_bad  = ex_badvaddr[32*i+:32];
      end
  end

  assign w_eret           = w_any & (w_code == C_ERET);
  assign w_take           = w_any & ~w_eret;
  assign w_wen            = w_hit & {6{~w_any}};
  assign w_tick           = r_div == DW'(COUNT_DIV - 1);
  assign w_inc            = w_tick & ~w_wen[1];
  assign w_cnt1           = r_count + 32'd1;
  assign exc_flush_all    = rst_ & w_any;
  assign cp0_if_excaddr   = !exc_flush_all ? 32'h0 : w_eret ? (w_hit[5] ? w_wd[5] : r_epc) : EXC_VEC;
  assign exc_flush_icache = r_flush;
  assign timer_int_o      = r_ti;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_badvaddr <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_epc      <= '0;
      r_im       <= 8'hFF;
      r_exl      <= 1'b0;
      r_ie       <= 1'b1;
      r_ip       <= '0;
      r_bd       <= 1'b0;
      r_ti       <= 1'b0;
      r_exc      <= '0;
      r_div      <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_flush <= w_any;
      r_ip    <= {int_i[5] | r_ti, int_i[4:0], w_wen[4] ? w_wd[4][9:8] : r_ip[1:0]};
      r_div   <= (w_wen[1] || w_tick) ? '0 : r_div + 1'b1;
      r_count <= w_wen[1] ? w_wd[1] : w_inc ? w_cnt1 : r_count;
      r_ti    <= w_wen[2] ? 1'b0 : (w_inc && w_cnt1 == r_compare) ? 1'b1 : r_ti;
      if (w_wen[0]) r_badvaddr <= w_wd[0];
      if (w_wen[2]) r_compare <= w_wd[2];
      if (w_wen[5]) r_epc <= w_wd[5];
      if (w_wen[3]) begin
        r_im  <= w_wd[3][15:8];
        r_exl <= w_wd[3][1];
        r_ie  <= w_wd[3][0];
      end
      if (w_take) begin
        if (!r_exl) begin
          r_epc <= w_dly ? w_pc - 32'd4 : w_pc;
          r_bd  <= w_dly;
        end
        r_exl <= 1'b1;
        r_exc <= w_code;
        if (w_code == 5'h04 || w_code == 5'h05) r_badvaddr <= w_bad;
      end
      if (w_eret) r_exl <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cp0_nway.sv
// tb_cp0_nway: directed-vector bench for the two-way cp0_nway configuration.
`timescale 1ns/1ps
module tb_cp0_nway;
  logic        clk = 1'b0, rst_ = 1'b1, ex_cp0_re = 1'b0;
  logic [9:0]  ex_cp0_raddr = '0, wb_cp0_waddr = '0, ex_exc_code = {5'h10, 5'h10};
  logic [63:0] ex_cp0_rdata, wb_cp0_wdata = '0, ex_exc_pc = '0, ex_badvaddr = '0;
  logic [1:0]  wb_cp0_we = '0, ex_in_delay = '0;
  logic [5:0]  int_i = '0;
  logic        exc_flush_all, exc_flush_icache, timer_int_o;
  logic [31:0] cp0_if_excaddr;
  int errs = 0, checks = 0;

  cp0_nway #(.WAYS(2), .COUNT_DIV(2), .EXC_VEC(32'hBFC00380)) dut (
    .clk(clk), .rst_(rst_), .ex_cp0_re(ex_cp0_re), .ex_cp0_raddr(ex_cp0_raddr),
    .ex_cp0_rdata(ex_cp0_rdata), .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr),
    .wb_cp0_wdata(wb_cp0_wdata), .int_i(int_i), .ex_exc_pc(ex_exc_pc),
    .ex_in_delay(ex_in_delay), .ex_exc_code(ex_exc_code), .ex_badvaddr(ex_badvaddr),
    .exc_flush_all(exc_flush_all), .exc_flush_icache(exc_flush_icache),
    .cp0_if_excaddr(cp0_if_excaddr), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wb_cp0_we = '0;
    ex_exc_code = {5'h10, 5'h10};
    ex_in_delay = '0;
    ex_exc_pc = '0;
    ex_badvaddr = '0;
  endtask

  task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
    wb_cp0_we[w] = 1'b1;
    wb_cp0_waddr[5*w+:5] = a;
    wb_cp0_wdata[32*w+:32] = d;
  endtask

  task automatic exc(input int w, input logic [4:0] c, input logic [31:0] pc, input logic dly, input logic [31:0] bad);
    ex_exc_code[5*w+:5] = c;
    ex_exc_pc[32*w+:32] = pc;
    ex_in_delay[w] = dly;
    ex_badvaddr[32*w+:32] = bad;
  endtask

  task automatic chkr(input string tag, input logic [4:0] a, input logic [31:0] exp);
    ex_cp0_raddr[4:0] = a;
    ex_cp0_re = 1'b1;
    #1;
    chk(tag, ex_cp0_rdata[31:0], exp);
  endtask

  initial begin
    #1 rst_ = 1'b0;
    exc(0, 5'h08, 32'h80001000, 1'b0, 32'h0);
    #1;
    chk("rst_flush_all", exc_flush_all, 0);
    chk("rst_excaddr", cp0_if_excaddr, 0);
    chk("rst_icache", exc_flush_icache, 0);
    idle();
    chkr("rst_status", 5'd12, 32'h0000FF01);
    chkr("rst_cause", 5'd13, 32'h0);
    chkr("rst_epc", 5'd14, 32'h0);
    tick();
    rst_ = 1'b1;
    chkr("post_rst_count", 5'd9, 32'h0);
    tick();
    // syscall on way 0
    exc(0, 5'h08, 32'h80001000, 1'b0, 32'h0);
    #1;
    chk("sys_flush_all", exc_flush_all, 1);
    chk("sys_excaddr", cp0_if_excaddr, 32'hBFC00380);
    chk("sys_icache_early", exc_flush_icache, 0);
    tick();
    idle();
    #1;
    chk("sys_icache", exc_flush_icache, 1);
    chk("idle_flush_all", exc_flush_all, 0);
    chk("idle_excaddr", cp0_if_excaddr, 0);
    chkr("sys_epc", 5'd14, 32'h80001000);
    chkr("sys_cause", 5'd13, 32'h00000020);
    chkr("sys_status", 5'd12, 32'h0000FF03);
    tick();
    chk("sys_icache_drop", exc_flush_icache, 0);
    wr(0, 5'd12, 32'h0000FF01);
    tick();
    idle();
    chkr("clr_exl", 5'd12, 32'h0000FF01);
    // AdEL in a delay slot on way 1
    exc(0, 5'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    exc(1, 5'h04, 32'h80002004, 1'b1, 32'h00000003);
    tick();
    idle();
    chkr("adel_epc", 5'd14, 32'h80002000);
    chkr("adel_cause", 5'd13, 32'h80000010);
    chkr("adel_badv", 5'd8, 32'h00000003);
    chkr("adel_status", 5'd12, 32'h0000FF03);
    // nested exception while EXL=1 keeps EPC/BD
    exc(0, 5'h08, 32'h80005000, 1'b1, 32'h0);
    tick();
    idle();
    chkr("nest_epc", 5'd14, 32'h80002000);
    chkr("nest_cause", 5'd13, 32'h80000020);
    chkr("nest_badv", 5'd8, 32'h00000003);
    // ERET with same-cycle EPC write
    exc(0, 5'h11, 32'h0, 1'b0, 32'h0);
    wr(0, 5'd14, 32'h80003000);
    #1;
    chk("eret_byp_addr", cp0_if_excaddr, 32'h80003000);
    chk("eret_flush", exc_flush_all, 1);
    tick();
    idle();
    chkr("eret_epc_kept", 5'd14, 32'h80002000);
    chkr("eret_status", 5'd12, 32'h0000FF01);
    exc(0, 5'h11, 32'h0, 1'b0, 32'h0);
    wr(0, 5'd14, 32'h11110000);
    wr(1, 5'd14, 32'h22220000);
    #1;
    chk("eret_byp_w1", cp0_if_excaddr, 32'h22220000);
    tick();
    idle();
    exc(1, 5'h11, 32'h0, 1'b0, 32'h0);
    #1;
    chk("eret_w1_addr", cp0_if_excaddr, 32'h80002000);
    tick();
    idle();
    chkr("eret_w1_epc", 5'd14, 32'h80002000);
    ex_cp0_raddr[9:5] = 5'd14;
    #1;
    chk("rd_way1", ex_cp0_rdata[63:32], 32'h80002000);
    chkr("rd_unmapped", 5'd15, 32'h0);
    ex_cp0_raddr[4:0] = 5'd14;
    ex_cp0_re = 1'b0;
    #1;
    chk("rd_re_low", ex_cp0_rdata[31:0], 32'h0);
    tick();
    // dual Status write, then dropped under exception
    wr(0, 5'd12, 32'h0000FF00);
    wr(1, 5'd12, 32'h00000401);
    tick();
    idle();
    chkr("dual_status", 5'd12, 32'h00000401);
    wr(0, 5'd12, 32'h0000FF00);
    wr(1, 5'd12, 32'h0000F001);
    exc(0, 5'h08, 32'h80006000, 1'b0, 32'h0);
    tick();
    idle();
    chkr("drop_status", 5'd12, 32'h00000403);
    chkr("drop_epc", 5'd14, 32'h80006000);
    chkr("drop_cause", 5'd13, 32'h00000020);
    // timer interrupt
    wr(0, 5'd12, 32'h00008001);
    wr(1, 5'd11, 32'h00000005);
    tick();
    idle();
    wr(0, 5'd9, 32'h0);
    tick();
    idle();
    chkr("tmr_count0", 5'd9, 32'h0);
    repeat (9) tick();
    chkr("tmr_count4", 5'd9, 32'h4);
    chk("tmr_ti_early", timer_int_o, 0);
    tick();
    chkr("tmr_count5", 5'd9, 32'h5);
    chk("tmr_ti", timer_int_o, 1);
    chk("tmr_no_int_yet", exc_flush_all, 0);
    tick();
    exc(0, 5'h10, 32'h80004000, 1'b0, 32'h0);
    #1;
    chk("tmr_int_flush", exc_flush_all, 1);
    chk("tmr_int_addr", cp0_if_excaddr, 32'hBFC00380);
    tick();
    idle();
    chkr("tmr_epc", 5'd14, 32'h80004000);
    chkr("tmr_cause", 5'd13, 32'h40008000);
    chkr("tmr_status", 5'd12, 32'h00008003);
    wr(0, 5'd11, 32'h00000100);
    tick();
    idle();
    chk("tmr_ti_clr", timer_int_o, 0);
    // Cause writes reach only IP[9:8]
    wr(0, 5'd13, 32'hFFFFFFFF);
    tick();
    idle();
    chkr("cause_sw", 5'd13, 32'h00000300);
    int_i = 6'b000100;
    tick();
    chkr("cause_hw", 5'd13, 32'h00001300);
    int_i = '0;
    wr(0, 5'd9, 32'hFFFFFFFF);
    tick();
    idle();
    chkr("cnt_load", 5'd9, 32'hFFFFFFFF);
    tick();
    tick();
    chkr("cnt_wrap", 5'd9, 32'h0);
    // reset in the middle of an exception
    exc(0, 5'h08, 32'h80007000, 1'b0, 32'h5);
    #1;
    chk("mid_flush", exc_flush_all, 1);
    rst_ = 1'b0;
    #1;
    chk("mid_rst_flush", exc_flush_all, 0);
    chk("mid_rst_addr", cp0_if_excaddr, 0);
    tick();
    rst_ = 1'b1;
    idle();
    chkr("mid_epc", 5'd14, 32'h0);
    chkr("mid_status", 5'd12, 32'h0000FF01);
    chkr("mid_cause", 5'd13, 32'h0);
    chkr("mid_count", 5'd9, 32'h0);
    chk("mid_icache", exc_flush_icache, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
